mic1_datapath: RTL and testbench

Execution datapath for the microcoded controller: the register file, ALU, shifter and micro-sequencer address logic that consume the controller's control word. The controller drives the control word on the falling edge of `clock`. This block executes it on the rising edge. It returns the resulting bus value `c_out` and the next micro-address `current_instruction` back to the controller.

---
 rtl/mic1_pkg.sv | 61 ++++++
 rtl/mic1_datapath_if.sv | 31 +++
 rtl/mic1_alu.sv | 58 +++++
 rtl/mic1_datapath.sv | 105 ++++++++++
 tb/tb_mic1_datapath.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/mic1_pkg.sv
// mic1_pkg: shared definitions for the MIC-1 controller and datapath.
// Holds ALU opcode constants, B-bus source codes, C-bus write-enable bit
// positions, jam bit positions and shifter codes. No ports.
package mic1_pkg;

  // ALU control word layout {F0,F1,ENA,ENB,INVA,INC}
  localparam int ALU_BIT_INC  = 0;
  localparam int ALU_BIT_INVA = 1;
  localparam int ALU_BIT_ENB  = 2;
  localparam int ALU_BIT_ENA  = 3;

  localparam logic [5:0] ALU_ZERO      = 6'b010000;
  localparam logic [5:0] ALU_ONE       = 6'b110001;
  localparam logic [5:0] ALU_MINUS1    = 6'b110010;
  localparam logic [5:0] ALU_B         = 6'b010100;
  localparam logic [5:0] ALU_A         = 6'b011000;
  localparam logic [5:0] ALU_A_PLUS_B  = 6'b111100;
  localparam logic [5:0] ALU_B_MINUS_A = 6'b111111;
  localparam logic [5:0] ALU_B_DEC     = 6'b110110;
  localparam logic [5:0] ALU_B_INC     = 6'b110101;
  localparam logic [5:0] ALU_A_INC     = 6'b111001;

  // B-bus source codes; 9..15 drive zero
  typedef enum logic [3:0] {
    B_MDR  = 4'd0,
    B_PC   = 4'd1,
    B_MBR  = 4'd2,
    B_MBRU = 4'd3,
    B_SP   = 4'd4,
    B_LV   = 4'd5,
    B_CPP  = 4'd6,
    B_TOS  = 4'd7,
    B_OPC  = 4'd8
  } bsel_e;

  // C-bus write-enable bit positions; also index the register file
  localparam int C_MAR    = 0;
  localparam int C_MDR    = 1;
  localparam int C_PC     = 2;
  localparam int C_SP     = 3;
  localparam int C_LV     = 4;
  localparam int C_CPP    = 5;
  localparam int C_TOS    = 6;
  localparam int C_OPC    = 7;
  localparam int C_H      = 8;
  localparam int NUM_REGS = 9;

  // jam field {JMPC,JAMN,JAMZ}
  localparam int JAM_Z = 0;
  localparam int JAM_N = 1;
  localparam int JAM_C = 2;

  // Shifter codes {SLL8,SRA1}; SLL8 wins when both are set
  typedef enum logic [1:0] {
    SH_NONE     = 2'b00,
    SH_SRA1     = 2'b01,
    SH_SLL8     = 2'b10,
    SH_SLL8_ALT = 2'b11
  } shift_e;

endpackage

// File: rtl/mic1_datapath_if.sv
// mic1_datapath_if: control word and result bus between the MIC-1
// controller (master) and the execution datapath (slave).
// Signals: next_instruction, alu_opcode, shifter_opcode, c_select,
// b_select, jam, m, mbr (controller -> datapath);
// current_instruction, c_out (datapath -> controller).
interface mic1_datapath_if #(
  parameter int WIDTH = 32
);
  logic [8:0]       next_instruction;
  logic [5:0]       alu_opcode;
  logic [1:0]       shifter_opcode;
  logic [8:0]       c_select;
  logic [3:0]       b_select;
  logic [2:0]       jam;
  logic [2:0]       m;
  logic [7:0]       mbr;
  logic [8:0]       current_instruction;
  logic [WIDTH-1:0] c_out;

  modport master (
    output next_instruction, alu_opcode, shifter_opcode, c_select,
           b_select, jam, m, mbr,
    input  current_instruction, c_out
  );

  modport slave (
    input  next_instruction, alu_opcode, shifter_opcode, c_select,
           b_select, jam, m, mbr,
    output current_instruction, c_out
  );
endinterface

// File: rtl/mic1_alu.sv
// mic1_alu: combinational MIC-1 ALU followed by the shifter.
// Ports: a_i (H operand), b_i (B-bus operand), alu_opcode_i
// {F0,F1,ENA,ENB,INVA,INC}, shifter_opcode_i {SLL8,SRA1};
// result_o (shifted result), n_o / z_o (flags of the unshifted result).
module mic1_alu
  import mic1_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [5:0]       alu_opcode_i,
  input  logic [1:0]       shifter_opcode_i,
  output logic [WIDTH-1:0] result_o,
  output logic             n_o,
  output logic             z_o
);

  logic [WIDTH-1:0] aOp;
  logic [WIDTH-1:0] bOp;
  logic [WIDTH-1:0] aluRes;
  logic [WIDTH-1:0] incVal;

  // Operand gating: INVA applies after ENA, so ENA=0,INVA=1 yields all ones
  always_comb begin
    aOp    = alu_opcode_i[ALU_BIT_ENA] ? a_i : '0;
    if (alu_opcode_i[ALU_BIT_INVA]) begin
      aOp = ~aOp;
    end
    bOp    = alu_opcode_i[ALU_BIT_ENB] ? b_i : '0;
    incVal = '0;
    incVal[0] = alu_opcode_i[ALU_BIT_INC];
  end

  always_comb begin
    unique case (alu_opcode_i[5:4])
      2'b00:   aluRes = aOp & bOp;
      2'b01:   aluRes = aOp | bOp;
      2'b10:   aluRes = ~bOp;
      default: aluRes = aOp + bOp + incVal;
    endcase
  end

  assign n_o = aluRes[WIDTH-1];
  assign z_o = (aluRes == '0);

  // SLL8 has priority so code 11 behaves like 10
  always_comb begin
    if (shifter_opcode_i[1]) begin
      result_o = {aluRes[WIDTH-9:0], 8'h00};
    end else if (shifter_opcode_i[0]) begin
      result_o = {aluRes[WIDTH-1], aluRes[WIDTH-1:1]};
    end else begin
      result_o = aluRes;
    end
  end

endmodule

// File: rtl/mic1_datapath.sv
// mic1_datapath: MIC-1 execution datapath. Register file (H, OPC, TOS,
// CPP, LV, SP, PC, MDR, MAR), B-bus mux, ALU/shifter, C-bus writes and
// the micro-program counter.
// Ports: clock, reset_n (async assert, release synchronised to clock),
// bus (slave side of mic1_datapath_if carrying the control word, mbr,
// c_out and current_instruction).
module mic1_datapath
  import mic1_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic           clock,
  input  logic           reset_n,
  mic1_datapath_if.slave bus
);

  logic [1:0]       rstSync_q;
  logic             rstInt_n;
  logic [WIDTH-1:0] reg_q [NUM_REGS];
  logic [WIDTH-1:0] reg_d [NUM_REGS];
  logic [WIDTH-1:0] cOut_q;
  logic [8:0]       mpc_q;
  logic [8:0]       mpc_d;
  logic [WIDTH-1:0] bBus;
  logic [WIDTH-1:0] shiftOut;
  logic             flagN;
  logic             flagZ;

  // Reset asserts immediately but releases only after two rising edges,
  // so no register leaves reset on a partial clock.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rstSync_q <= 2'b00;
    end else begin
      rstSync_q <= {rstSync_q[0], 1'b1};
    end
  end

  assign rstInt_n = rstSync_q[1];

  // MAR is write-only, so it never appears on B
  always_comb begin
    unique case (bus.b_select)
      B_MDR:   bBus = reg_q[C_MDR];
      B_PC:    bBus = reg_q[C_PC];
      B_MBR:   bBus = {{(WIDTH-8){bus.mbr[7]}}, bus.mbr};
      B_MBRU:  bBus = {{(WIDTH-8){1'b0}}, bus.mbr};
      B_SP:    bBus = reg_q[C_SP];
      B_LV:    bBus = reg_q[C_LV];
      B_CPP:   bBus = reg_q[C_CPP];
      B_TOS:   bBus = reg_q[C_TOS];
      B_OPC:   bBus = reg_q[C_OPC];
      default: bBus = '0;
    endcase
  end

  mic1_alu #(
    .WIDTH(WIDTH)
  ) u_alu (
    .a_i              (reg_q[C_H]),
    .b_i              (bBus),
    .alu_opcode_i     (bus.alu_opcode),
    .shifter_opcode_i (bus.shifter_opcode),
    .result_o         (shiftOut),
    .n_o              (flagN),
    .z_o              (flagZ)
  );

  // Any number of destinations may be written from one C-bus value
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      reg_d[i] = bus.c_select[i] ? shiftOut : reg_q[i];
    end
  end

  always_comb begin
    mpc_d    = bus.next_instruction;
    mpc_d[8] = bus.next_instruction[8]
             | (bus.jam[JAM_N] & flagN)
             | (bus.jam[JAM_Z] & flagZ);
    if (bus.jam[JAM_C]) begin
      mpc_d[7:0] = bus.next_instruction[7:0] | bus.mbr;
    end
  end

  always_ff @(posedge clock or negedge rstInt_n) begin
    if (!rstInt_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        reg_q[i] <= '0;
      end
      cOut_q <= '0;
      mpc_q  <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        reg_q[i] <= reg_d[i];
      end
      cOut_q <= shiftOut;
      mpc_q  <= mpc_d;
    end
  end

  assign bus.c_out               = cOut_q;
  assign bus.current_instruction = mpc_q;

endmodule

// File: tb/tb_mic1_datapath.sv
// tb_mic1_datapath: self-checking bench for mic1_datapath. Drives the
// control word on the falling edge like the real controller and checks
// c_out / current_instruction on the next falling edge.
module tb_mic1_datapath;
  import mic1_pkg::*;

  logic clock  = 1'b0;
  logic resetN = 1'b0;
  int   errorCount = 0;
  int   checkCount = 0;

  logic [31:0] modelReg [9];

  mic1_datapath_if #(.WIDTH(32)) dpIf ();

  mic1_datapath #(
    .WIDTH(32)
  ) dut (
    .clock   (clock),
    .reset_n (resetN),
    .bus     (dpIf.slave)
  );

  // Free-running clock, 10 time units per cycle
  always #5 clock = ~clock;

  // Hard stop in case the run ever stalls
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish, errors=%0d", errorCount);
    $fatal(1, "[TB] watchdog expired");
  end

  typedef struct {
    logic [5:0]  aluOp;
    logic [1:0]  shOp;
    logic [8:0]  cSel;
    logic [3:0]  bSel;
    logic [2:0]  jam;
    logic [8:0]  nextInst;
    logic [7:0]  mbr;
    logic [31:0] expC;
    logic [8:0]  expMpc;
  } vec_t;

  vec_t vecs[26];

  function automatic vec_t mkVec(logic [5:0] aluOp, logic [1:0] shOp, logic [8:0] cSel,
                                 logic [3:0] bSel, logic [2:0] jam, logic [8:0] nextInst,
                                 logic [7:0] mbr, logic [31:0] expC, logic [8:0] expMpc);
    vec_t v;
    v.aluOp = aluOp; v.shOp = shOp; v.cSel = cSel; v.bSel = bSel; v.jam = jam;
    v.nextInst = nextInst; v.mbr = mbr; v.expC = expC; v.expMpc = expMpc;
    return v;
  endfunction

  task automatic compare(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [5:0] aluOp, input logic [1:0] shOp,
                               input logic [8:0] cSel, input logic [3:0] bSel,
                               input logic [2:0] jam, input logic [8:0] nextInst,
                               input logic [7:0] mbr);
    dpIf.alu_opcode       = aluOp;
    dpIf.shifter_opcode   = shOp;
    dpIf.c_select         = cSel;
    dpIf.b_select         = bSel;
    dpIf.jam              = jam;
    dpIf.next_instruction = nextInst;
    dpIf.mbr              = mbr;
    dpIf.m                = 3'($urandom);
  endtask

  task automatic checkOutput(input string name, input logic [31:0] expC, input logic [8:0] expMpc);
    compare({name, " c_out"}, dpIf.c_out, expC);
    compare({name, " mpc"}, {23'b0, dpIf.current_instruction}, {23'b0, expMpc});
  endtask

  // Reference model: one micro-instruction applied to the abstract register
  // array (indexed by c_select bit position), returning the expected outputs.
  task automatic modelStep(input logic [5:0] aluOp, input logic [1:0] shOp,
                           input logic [8:0] cSel, input logic [3:0] bSel,
                           input logic [2:0] jam, input logic [8:0] nextInst,
                           input logic [7:0] mbr,
                           output logic [31:0] expC, output logic [8:0] expMpc);
    logic [31:0] bVal, aV, bV, res;
    logic        n, z;
    case (bSel)
      4'd0: bVal = modelReg[1];
      4'd1: bVal = modelReg[2];
      4'd2: bVal = 32'($signed(mbr));
      4'd3: bVal = 32'(mbr);
      4'd4: bVal = modelReg[3];
      4'd5: bVal = modelReg[4];
      4'd6: bVal = modelReg[5];
      4'd7: bVal = modelReg[6];
      4'd8: bVal = modelReg[7];
      default: bVal = 32'd0;
    endcase
    aV = aluOp[3] ? modelReg[8] : 32'd0;
    if (aluOp[1]) aV = ~aV;
    bV = aluOp[2] ? bVal : 32'd0;
    case (aluOp[5:4])
      2'd0:    res = aV & bV;
      2'd1:    res = aV | bV;
      2'd2:    res = ~bV;
      default: res = aV + bV + 32'(aluOp[0]);
    endcase
    n = res[31];
    z = (res == 32'd0);
    if (shOp[1])      expC = res * 32'd256;
    else if (shOp[0]) expC = 32'($signed(res) >>> 1);
    else              expC = res;
    for (int i = 0; i < 9; i++) begin
      if (cSel[i]) modelReg[i] = expC;
    end
    expMpc[8]   = nextInst[8] | (jam[1] & n) | (jam[0] & z);
    expMpc[7:0] = nextInst[7:0] | (jam[2] ? mbr : 8'h00);
  endtask

  initial begin
    logic [31:0] expC;
    logic [8:0]  expMpc;
    logic [5:0]  rAlu;
    logic [1:0]  rSh;
    logic [8:0]  rCs, rNext;
    logic [3:0]  rBs;
    logic [2:0]  rJam;
    logic [7:0]  rMbr;

    vecs[0]  = mkVec(ALU_ZERO,      2'b00, 9'h000, 4'd0, 3'b001, 9'h012, 8'h00, 32'h0000_0000, 9'h112);
    vecs[1]  = mkVec(ALU_ZERO,      2'b00, 9'h000, 4'd0, 3'b000, 9'h012, 8'h00, 32'h0000_0000, 9'h012);
    vecs[2]  = mkVec(ALU_MINUS1,    2'b00, 9'h000, 4'd0, 3'b010, 9'h004, 8'h00, 32'hFFFF_FFFF, 9'h104);
    vecs[3]  = mkVec(ALU_ZERO,      2'b00, 9'h000, 4'd0, 3'b100, 9'h000, 8'hA5, 32'h0000_0000, 9'h0A5);
    vecs[4]  = mkVec(ALU_ONE,       2'b00, 9'h1C0, 4'd0, 3'b000, 9'h001, 8'h00, 32'h0000_0001, 9'h001);
    vecs[5]  = mkVec(ALU_A,         2'b00, 9'h000, 4'd0, 3'b000, 9'h002, 8'h00, 32'h0000_0001, 9'h002);
    vecs[6]  = mkVec(ALU_B,         2'b00, 9'h000, 4'd8, 3'b000, 9'h003, 8'h00, 32'h0000_0001, 9'h003);
    vecs[7]  = mkVec(ALU_B,         2'b00, 9'h000, 4'd7, 3'b000, 9'h004, 8'h00, 32'h0000_0001, 9'h004);
    vecs[8]  = mkVec(ALU_B_INC,     2'b00, 9'h040, 4'd7, 3'b000, 9'h005, 8'h00, 32'h0000_0002, 9'h005);
    vecs[9]  = mkVec(ALU_B_INC,     2'b00, 9'h040, 4'd7, 3'b000, 9'h006, 8'h00, 32'h0000_0003, 9'h006);
    vecs[10] = mkVec(ALU_A_PLUS_B,  2'b00, 9'h000, 4'd7, 3'b000, 9'h007, 8'h00, 32'h0000_0004, 9'h007);
    vecs[11] = mkVec(ALU_B_MINUS_A, 2'b00, 9'h000, 4'd7, 3'b000, 9'h008, 8'h00, 32'h0000_0002, 9'h008);
    vecs[12] = mkVec(ALU_B_DEC,     2'b00, 9'h000, 4'd7, 3'b000, 9'h009, 8'h00, 32'h0000_0002, 9'h009);
    vecs[13] = mkVec(ALU_B,         2'b00, 9'h100, 4'd3, 3'b000, 9'h00A, 8'h81, 32'h0000_0081, 9'h00A);
    vecs[14] = mkVec(ALU_A,         2'b10, 9'h000, 4'd0, 3'b000, 9'h00B, 8'h00, 32'h0000_8100, 9'h00B);
    vecs[15] = mkVec(ALU_A,         2'b11, 9'h000, 4'd0, 3'b000, 9'h00C, 8'h00, 32'h0000_8100, 9'h00C);
    vecs[16] = mkVec(ALU_B,         2'b00, 9'h000, 4'd2, 3'b010, 9'h00D, 8'h80, 32'hFFFF_FF80, 9'h10D);
    vecs[17] = mkVec(ALU_B,         2'b00, 9'h000, 4'd9, 3'b001, 9'h00E, 8'h00, 32'h0000_0000, 9'h10E);
    vecs[18] = mkVec(ALU_B,         2'b10, 9'h100, 4'd3, 3'b000, 9'h010, 8'h80, 32'h0000_8000, 9'h010);
    vecs[19] = mkVec(ALU_A,         2'b10, 9'h100, 4'd0, 3'b000, 9'h011, 8'h00, 32'h0080_0000, 9'h011);
    vecs[20] = mkVec(ALU_A,         2'b10, 9'h100, 4'd0, 3'b000, 9'h012, 8'h00, 32'h8000_0000, 9'h012);
    vecs[21] = mkVec(ALU_B,         2'b00, 9'h002, 4'd3, 3'b000, 9'h013, 8'h02, 32'h0000_0002, 9'h013);
    vecs[22] = mkVec(ALU_A_PLUS_B,  2'b00, 9'h100, 4'd0, 3'b000, 9'h014, 8'h00, 32'h8000_0002, 9'h014);
    vecs[23] = mkVec(ALU_A,         2'b01, 9'h000, 4'd0, 3'b010, 9'h015, 8'h00, 32'hC000_0001, 9'h115);
    vecs[24] = mkVec(ALU_B,         2'b00, 9'h000, 4'd1, 3'b100, 9'h0F0, 8'h0F, 32'h0000_0000, 9'h0FF);
    vecs[25] = mkVec(ALU_ONE,       2'b00, 9'h1FF, 4'd0, 3'b000, 9'h1FF, 8'h00, 32'h0000_0001, 9'h1FF);

    // Reset state
    applyStimulus(ALU_ZERO, 2'b00, 9'h000, 4'd0, 3'b000, 9'h000, 8'h00);
    #1;
    checkOutput("reset", 32'h0, 9'h000);
    repeat (2) @(negedge clock);
    resetN = 1'b1;
    repeat (3) @(negedge clock);

    // Directed table, run back to back from the reset state
    for (int i = 0; i < 26; i++) begin
      applyStimulus(vecs[i].aluOp, vecs[i].shOp, vecs[i].cSel, vecs[i].bSel,
                    vecs[i].jam, vecs[i].nextInst, vecs[i].mbr);
      @(negedge clock);
      checkOutput($sformatf("vec%0d", i), vecs[i].expC, vecs[i].expMpc);
    end

    // Asynchronous reset between edges, held two cycles, then released
    applyStimulus(ALU_MINUS1, 2'b00, 9'h100, 4'd0, 3'b000, 9'h1AB, 8'h00);
    @(negedge clock);
    checkOutput("preReset", 32'hFFFF_FFFF, 9'h1AB);
    @(posedge clock);
    #2;
    resetN = 1'b0;
    #1;
    checkOutput("asyncReset", 32'h0, 9'h000);
    repeat (2) @(negedge clock);
    resetN = 1'b1;
    applyStimulus(ALU_ZERO, 2'b00, 9'h000, 4'd0, 3'b000, 9'h000, 8'h00);
    @(negedge clock);
    checkOutput("release", 32'h0, 9'h000);
    repeat (2) @(negedge clock);
    applyStimulus(ALU_A, 2'b00, 9'h000, 4'd0, 3'b000, 9'h055, 8'h00);
    @(negedge clock);
    checkOutput("hCleared", 32'h0, 9'h055);

    // Randomised control words against the reference model
    for (int i = 0; i < 9; i++) modelReg[i] = 32'd0;
    for (int i = 0; i < 400; i++) begin
      rAlu  = 6'($urandom);
      rSh   = 2'($urandom);
      rCs   = 9'($urandom);
      rBs   = 4'($urandom_range(0, 15));
      rJam  = 3'($urandom);
      rNext = 9'($urandom);
      rMbr  = 8'($urandom);
      modelStep(rAlu, rSh, rCs, rBs, rJam, rNext, rMbr, expC, expMpc);
      applyStimulus(rAlu, rSh, rCs, rBs, rJam, rNext, rMbr);
      @(negedge clock);
      checkOutput($sformatf("rand%0d", i), expC, expMpc);
    end

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
